// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute <-> branch resolve unit bundle: allocation, resolution and retire-update signals.
// master: fetch/execute side, drives alloc*/resolve* and observes tag, freeze and the update outputs.
// slave: the resolve unit, receives alloc*/resolve* and drives allocTag, freeze and all retire outputs.
interface branch_resolve_unit_if #(
    parameter int WIDTH = 31,
    parameter int INDEX = 7,
    parameter int TAG_W = 3
);
    // allocation from fetch
    logic             allocValid;
    logic [WIDTH:0]   allocPC;
    logic [WIDTH:0]   allocPredictedPC;
    logic             allocRedirect;
    logic [INDEX:0]   allocGHRIndex;
    logic [1:0]       allocPHTState;
    logic             allocIsJAL;
    logic [TAG_W-1:0] allocTag;
    // resolution from execute
    logic             resolveValid;
    logic [TAG_W-1:0] resolveTag;
    logic             resolveTaken;
    logic [WIDTH:0]   resolveTarget;
    // retire / recovery back to fetch
    logic             freeze;
    logic             mispredict;
    logic             misdirect;
    logic [WIDTH:0]   validAddress;
    logic [WIDTH:0]   target;
    logic [WIDTH:0]   oldPC;
    logic             writeBTB;
    logic             isControl;
    logic             takenBranch;
    logic             branch;
    logic             isJAL;
    logic [INDEX:0]   updateIndex;
    logic [1:0]       newState;

    modport master (
        output allocValid, allocPC, allocPredictedPC, allocRedirect,
               allocGHRIndex, allocPHTState, allocIsJAL,
               resolveValid, resolveTag, resolveTaken, resolveTarget,
        input  allocTag, freeze, mispredict, misdirect, validAddress, target,
               oldPC, writeBTB, isControl, takenBranch, branch, isJAL,
               updateIndex, newState
    );

    modport slave (
        input  allocValid, allocPC, allocPredictedPC, allocRedirect,
               allocGHRIndex, allocPHTState, allocIsJAL,
               resolveValid, resolveTag, resolveTaken, resolveTarget,
        output allocTag, freeze, mispredict, misdirect, validAddress, target,
               oldPC, writeBTB, isControl, takenBranch, branch, isJAL,
               updateIndex, newState
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order retire queue for fetched control instructions with out-of-order resolution.
// Latency: a resolve sampled at edge E makes the entry eligible; its retire outputs appear after edge E+1.
// Backpressure: freeze is raised while all DEPTH slots are occupied; allocations while full are dropped.
//
// Ports:
//   clk, reset : clock (rising edge) and asynchronous active-high reset
//   bus        : slave side of branch_resolve_unit_if
//                alloc*   - metadata of a fetched control instruction, allocTag returns its slot id
//                resolve* - actual outcome of a slot from execute (any order)
//                outputs  - registered retire pulses (mispredict, misdirect, writeBTB, isControl,
//                           branch) and held retire data (validAddress, target, oldPC, takenBranch,
//                           isJAL, updateIndex, newState); freeze is combinational from occupancy
module branch_resolve_unit #(
    parameter int WIDTH = 31,
    parameter int INDEX = 7,
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_unit_if.slave  bus
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);
    localparam logic [WIDTH:0] PC_STEP    = (WIDTH+1)'(4);

    // Per-slot payload; valid/resolved flags live in separate vectors so only they need reset.
    typedef struct packed {
        logic [WIDTH:0] pc;
        logic [WIDTH:0] pred_pc;
        logic           redirect;
        logic [INDEX:0] ghr_index;
        logic [1:0]     pht_state;
        logic           is_jal;
        logic           taken;
        logic [WIDTH:0] res_target;
    } entry_t;

    entry_t             ent [DEPTH];
    logic [DEPTH-1:0]   ent_valid;
    logic [DEPTH-1:0]   ent_resolved;

    logic [TAG_W-1:0]   head;
    logic [TAG_W-1:0]   tail;
    logic [TAG_W:0]     count;

    logic               full;
    logic               retire;
    logic               head_taken;
    logic               ret_mispredict;
    logic               ret_misdirect;
    logic               flush;
    logic               do_alloc;
    logic               do_resolve;
    logic [WIDTH:0]     ret_next_pc;
    logic [1:0]         ret_state;
    entry_t             head_ent;

    // Registered retire outputs
    logic               mispredict_q;
    logic               misdirect_q;
    logic               write_btb_q;
    logic               is_control_q;
    logic               branch_q;
    logic               taken_q;
    logic               is_jal_q;
    logic [WIDTH:0]     valid_address_q;
    logic [WIDTH:0]     target_q;
    logic [WIDTH:0]     old_pc_q;
    logic [INDEX:0]     update_index_q;
    logic [1:0]         new_state_q;

    assign full         = (count == FULL_COUNT);
    assign bus.freeze   = full;
    assign bus.allocTag = tail;

    // Retire decision and outcome of the head entry
    always_comb begin
        head_ent       = ent[head];
        retire         = ent_valid[head] & ent_resolved[head];
        // Jumps are always taken regardless of what execute reported.
        head_taken     = head_ent.is_jal | head_ent.taken;
        ret_mispredict = (head_taken != head_ent.redirect);
        ret_misdirect  = head_taken & head_ent.redirect &
                         (head_ent.res_target != head_ent.pred_pc);
        flush          = retire & (ret_mispredict | ret_misdirect);
        // Everything younger than a wrong-path retire is discarded, including this cycle's traffic.
        do_alloc       = bus.allocValid & ~full & ~flush;
        do_resolve     = bus.resolveValid & ent_valid[bus.resolveTag] & ~flush;
        ret_next_pc    = head_taken ? head_ent.res_target : (head_ent.pc + PC_STEP);

        ret_state = head_ent.pht_state;
        if (head_taken) begin
            if (head_ent.pht_state != 2'b11) begin
                ret_state = head_ent.pht_state + 2'd1;
            end
        end else begin
            if (head_ent.pht_state != 2'b00) begin
                ret_state = head_ent.pht_state - 2'd1;
            end
        end
    end

    // Queue control: pointers, occupancy and slot flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ent_valid    <= '0;
            ent_resolved <= '0;
        end else if (flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ent_valid    <= '0;
            ent_resolved <= '0;
        end else begin
            if (do_alloc) begin
                ent_valid[tail]    <= 1'b1;
                ent_resolved[tail] <= 1'b0;
                tail               <= tail + 1'b1;
            end
            if (do_resolve) begin
                ent_resolved[bus.resolveTag] <= 1'b1;
            end
            // Placed last so a late resolve to the retiring slot cannot revive it.
            if (retire) begin
                ent_valid[head]    <= 1'b0;
                ent_resolved[head] <= 1'b0;
                head               <= head + 1'b1;
            end
            case ({do_alloc, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Slot payload; stale contents of freed slots are never observed because the flags gate them.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            ent[tail].pc         <= bus.allocPC;
            ent[tail].pred_pc    <= bus.allocPredictedPC;
            ent[tail].redirect   <= bus.allocRedirect;
            ent[tail].ghr_index  <= bus.allocGHRIndex;
            ent[tail].pht_state  <= bus.allocPHTState;
            ent[tail].is_jal     <= bus.allocIsJAL;
            ent[tail].taken      <= 1'b0;
            ent[tail].res_target <= '0;
        end
        if (do_resolve) begin
            ent[bus.resolveTag].taken      <= bus.resolveTaken;
            ent[bus.resolveTag].res_target <= bus.resolveTarget;
        end
    end

    // Retire outputs: pulses last one cycle, data holds until the next retire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredict_q    <= 1'b0;
            misdirect_q     <= 1'b0;
            write_btb_q     <= 1'b0;
            is_control_q    <= 1'b0;
            branch_q        <= 1'b0;
            taken_q         <= 1'b0;
            is_jal_q        <= 1'b0;
            valid_address_q <= '0;
            target_q        <= '0;
            old_pc_q        <= '0;
            update_index_q  <= '0;
            new_state_q     <= '0;
        end else begin
            mispredict_q <= retire & ret_mispredict;
            misdirect_q  <= retire & ret_misdirect;
            write_btb_q  <= retire & head_taken;
            is_control_q <= retire;
            branch_q     <= retire & ~head_ent.is_jal;
            if (retire) begin
                taken_q         <= head_taken;
                is_jal_q        <= head_ent.is_jal;
                valid_address_q <= ret_next_pc;
                target_q        <= head_ent.res_target;
                old_pc_q        <= head_ent.pc;
                update_index_q  <= head_ent.ghr_index;
                new_state_q     <= ret_state;
            end
        end
    end

    assign bus.mispredict   = mispredict_q;
    assign bus.misdirect    = misdirect_q;
    assign bus.writeBTB     = write_btb_q;
    assign bus.isControl    = is_control_q;
    assign bus.branch       = branch_q;
    assign bus.takenBranch  = taken_q;
    assign bus.isJAL        = is_jal_q;
    assign bus.validAddress = valid_address_q;
    assign bus.target       = target_q;
    assign bus.oldPC        = old_pc_q;
    assign bus.updateIndex  = update_index_q;
    assign bus.newState     = new_state_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios plus a randomized run against a queue model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: the model mirrors freeze as "queue holds DEPTH entries".
module tb_branch_resolve_unit;
    localparam int WIDTH = 31;
    localparam int INDEX = 7;
    localparam int DEPTH = 8;
    localparam int TAG_W = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.WIDTH(WIDTH), .INDEX(INDEX), .TAG_W(TAG_W)) bus ();

    branch_resolve_unit #(.WIDTH(WIDTH), .INDEX(INDEX), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: program-ordered queue of in-flight control instructions.
    typedef struct {
        int          tag;
        logic [31:0] pc;
        logic [31:0] pred;
        logic        redirect;
        logic [7:0]  idx;
        logic [1:0]  st;
        logic        jal;
        logic        res;
        logic        taken;
        logic [31:0] tgt;
    } ment_t;

    ment_t mq[$];
    int    mtail;

    logic        e_mis, e_misd, e_wbtb, e_isc, e_br, e_taken, e_jal;
    logic [31:0] e_va, e_tgt, e_old;
    logic [7:0]  e_idx;
    logic [1:0]  e_ns;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_clear();
        mq.delete();
        mtail = 0;
        {e_mis, e_misd, e_wbtb, e_isc, e_br, e_taken, e_jal} = '0;
        e_va = '0; e_tgt = '0; e_old = '0; e_idx = '0; e_ns = '0;
    endtask

    task automatic idle();
        bus.allocValid   = 1'b0;
        bus.resolveValid = 1'b0;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input logic [31:0] pred, input logic redirect,
                             input logic [7:0] idx, input logic [1:0] st, input logic jal);
        bus.allocValid       = 1'b1;
        bus.allocPC          = pc;
        bus.allocPredictedPC = pred;
        bus.allocRedirect    = redirect;
        bus.allocGHRIndex    = idx;
        bus.allocPHTState    = st;
        bus.allocIsJAL       = jal;
    endtask

    task automatic set_resolve(input int tag, input logic taken, input logic [31:0] tgt);
        bus.resolveValid  = 1'b1;
        bus.resolveTag    = 3'(tag);
        bus.resolveTaken  = taken;
        bus.resolveTarget = tgt;
    endtask

    // Advance the model by one cycle from the currently driven inputs, then clock the DUT.
    task automatic tick();
        bit    full, ret, fl, tk;
        int    s;
        ment_t h, n;
        full = (mq.size() == DEPTH);
        ret  = (mq.size() > 0) && mq[0].res;
        fl   = 0;
        {e_mis, e_misd, e_wbtb, e_isc, e_br} = '0;
        if (ret) begin
            h      = mq[0];
            tk     = h.jal | h.taken;
            e_mis  = (tk != h.redirect);
            e_misd = tk && h.redirect && (h.tgt != h.pred);
            e_va   = tk ? h.tgt : h.pc + 32'd4;
            e_tgt  = h.tgt;
            e_old  = h.pc;
            e_wbtb = tk;
            e_isc  = 1'b1;
            e_taken = tk;
            e_br   = !h.jal;
            e_jal  = h.jal;
            e_idx  = h.idx;
            s      = int'(h.st);
            s      = tk ? ((s < 3) ? s + 1 : 3) : ((s > 0) ? s - 1 : 0);
            e_ns   = 2'(s);
            fl     = e_mis | e_misd;
        end
        if (fl) begin
            mq.delete();
            mtail = 0;
        end else begin
            if (bus.resolveValid) begin
                foreach (mq[i]) begin
                    if (mq[i].tag == int'(bus.resolveTag)) begin
                        mq[i].res   = 1'b1;
                        mq[i].taken = bus.resolveTaken;
                        mq[i].tgt   = bus.resolveTarget;
                    end
                end
            end
            if (ret) void'(mq.pop_front());
            if (bus.allocValid && !full) begin
                n.tag = mtail; n.pc = bus.allocPC; n.pred = bus.allocPredictedPC;
                n.redirect = bus.allocRedirect; n.idx = bus.allocGHRIndex; n.st = bus.allocPHTState;
                n.jal = bus.allocIsJAL; n.res = 1'b0; n.taken = 1'b0; n.tgt = '0;
                mq.push_back(n);
                mtail = (mtail + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        idle();
        #2;
        model_clear();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        hold_reset();
        n_checks++;
        if ({bus.freeze, bus.allocTag, bus.isControl, bus.mispredict, bus.validAddress} !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: got frz=%0b tag=%0d isc=%0b mp=%0b va=%h, want all 0",
                     bus.freeze, bus.allocTag, bus.isControl, bus.mispredict, bus.validAddress);
        end
        release_reset();
        for (int i = 0; i < 6; i++) begin
            set_alloc(32'h1000 + 32'(4 * i), 32'h0, 1'b0, 8'(i), 2'b01, 1'b0);
            tick();
        end
        idle();
        set_resolve(0, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        n_checks++;
        if ({bus.oldPC, bus.validAddress, bus.allocTag} !== {32'h1000, 32'h1004, 3'd6}) begin
            n_fail++;
            $display("FAIL reset_prefill: got old=%h va=%h tag=%0d, want 1000 1004 6",
                     bus.oldPC, bus.validAddress, bus.allocTag);
        end
        hold_reset();
        n_checks++;
        if ({bus.oldPC, bus.validAddress, bus.updateIndex, bus.newState, bus.allocTag, bus.freeze} !== '0) begin
            n_fail++;
            $display("FAIL reset_midqueue: got old=%h va=%h idx=%h ns=%0d tag=%0d frz=%0b, want all 0",
                     bus.oldPC, bus.validAddress, bus.updateIndex, bus.newState, bus.allocTag, bus.freeze);
        end
        release_reset();
        n_checks++;
        if ({bus.isControl, bus.takenBranch, bus.target, bus.allocTag} !== '0) begin
            n_fail++;
            $display("FAIL reset_nextclk: got isc=%0b tb=%0b tgt=%h tag=%0d, want all 0",
                     bus.isControl, bus.takenBranch, bus.target, bus.allocTag);
        end
        set_alloc(32'h2000, 32'h0, 1'b0, 8'h0, 2'b00, 1'b0);
        tick();
        idle();
        n_checks++;
        if (bus.allocTag !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_first_tag: got tag=%0d want 1 (first alloc used tag 0)", bus.allocTag);
        end
    endtask

    task automatic test_mispredict();
        hold_reset();
        release_reset();
        set_alloc(32'h100, 32'h104, 1'b0, 8'h3A, 2'b01, 1'b0);
        tick();
        idle();
        set_resolve(0, 1'b1, 32'h200);
        tick();
        idle();
        n_checks++;
        if (bus.isControl !== 1'b0) begin
            n_fail++;
            $display("FAIL mp_latency: got isControl=%0b one edge after resolve, want 0", bus.isControl);
        end
        tick();
        n_checks++;
        if ({bus.mispredict, bus.misdirect, bus.writeBTB, bus.branch, bus.isControl, bus.takenBranch,
             bus.validAddress, bus.updateIndex, bus.newState, bus.oldPC}
            !== {6'b101111, 32'h200, 8'h3A, 2'b10, 32'h100}) begin
            n_fail++;
            $display("FAIL mp_retire: got mp=%0b md=%0b wb=%0b br=%0b isc=%0b tb=%0b va=%h idx=%h ns=%0b old=%h",
                     bus.mispredict, bus.misdirect, bus.writeBTB, bus.branch, bus.isControl, bus.takenBranch,
                     bus.validAddress, bus.updateIndex, bus.newState, bus.oldPC);
        end
        tick();
        n_checks++;
        if ({bus.mispredict, bus.isControl, bus.writeBTB, bus.branch, bus.freeze, bus.allocTag, bus.validAddress}
            !== {5'b0, 3'd0, 32'h200}) begin
            n_fail++;
            $display("FAIL mp_after: got mp=%0b isc=%0b wb=%0b br=%0b frz=%0b tag=%0d va=%h, want pulses 0 tag 0 va 200",
                     bus.mispredict, bus.isControl, bus.writeBTB, bus.branch, bus.freeze, bus.allocTag, bus.validAddress);
        end
    endtask

    task automatic test_misdirect();
        hold_reset();
        release_reset();
        set_alloc(32'h300, 32'h400, 1'b1, 8'h11, 2'b11, 1'b0);
        tick();
        for (int i = 1; i < 4; i++) begin
            set_alloc(32'h400 + 32'(4 * i), 32'h0, 1'b0, 8'(i), 2'b01, 1'b0);
            tick();
        end
        idle();
        set_resolve(0, 1'b1, 32'h480);
        tick();
        idle();
        tick();
        n_checks++;
        if ({bus.misdirect, bus.mispredict, bus.writeBTB, bus.isControl, bus.newState, bus.validAddress, bus.target}
            !== {4'b1011, 2'b11, 32'h480, 32'h480}) begin
            n_fail++;
            $display("FAIL md_retire: got md=%0b mp=%0b wb=%0b isc=%0b ns=%0b va=%h tgt=%h, want 1 0 1 1 11 480 480",
                     bus.misdirect, bus.mispredict, bus.writeBTB, bus.isControl, bus.newState, bus.validAddress, bus.target);
        end
        n_checks++;
        if ({bus.allocTag, bus.freeze} !== 4'b0) begin
            n_fail++;
            $display("FAIL md_flush_ptr: got tag=%0d frz=%0b, want 0 0", bus.allocTag, bus.freeze);
        end
        // Younger entries must be gone: resolving them retires nothing.
        set_resolve(1, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        tick();
        n_checks++;
        if (bus.isControl !== 1'b0) begin
            n_fail++;
            $display("FAIL md_flushed_entries: got isControl=%0b after resolving a flushed slot, want 0", bus.isControl);
        end
    endtask

    task automatic test_in_order();
        hold_reset();
        release_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(32'h500 + 32'(4 * i), 32'h900, 1'b0, 8'(i + 1), 2'(2 - i), 1'b0);
            tick();
        end
        idle();
        set_resolve(2, 1'b0, 32'h0);
        tick();
        n_checks++;
        if (bus.isControl !== 1'b0) begin
            n_fail++;
            $display("FAIL order_wait2: got isControl=%0b with head unresolved, want 0", bus.isControl);
        end
        set_resolve(0, 1'b0, 32'h0);
        tick();
        n_checks++;
        if (bus.isControl !== 1'b0) begin
            n_fail++;
            $display("FAIL order_wait0: got isControl=%0b on resolve edge of head, want 0", bus.isControl);
        end
        set_resolve(1, 1'b0, 32'h0);
        tick();
        idle();
        n_checks++;
        if ({bus.isControl, bus.mispredict, bus.writeBTB, bus.oldPC, bus.validAddress, bus.updateIndex, bus.newState}
            !== {3'b100, 32'h500, 32'h504, 8'h1, 2'b01}) begin
            n_fail++;
            $display("FAIL order_ret0: got isc=%0b mp=%0b wb=%0b old=%h va=%h idx=%h ns=%0b, want 1 0 0 500 504 01 01",
                     bus.isControl, bus.mispredict, bus.writeBTB, bus.oldPC, bus.validAddress, bus.updateIndex, bus.newState);
        end
        tick();
        n_checks++;
        if ({bus.isControl, bus.oldPC, bus.validAddress, bus.newState} !== {1'b1, 32'h504, 32'h508, 2'b00}) begin
            n_fail++;
            $display("FAIL order_ret1: got isc=%0b old=%h va=%h ns=%0b, want 1 504 508 00",
                     bus.isControl, bus.oldPC, bus.validAddress, bus.newState);
        end
        tick();
        n_checks++;
        if ({bus.isControl, bus.oldPC, bus.validAddress, bus.newState} !== {1'b1, 32'h508, 32'h50C, 2'b00}) begin
            n_fail++;
            $display("FAIL order_ret2: got isc=%0b old=%h va=%h ns=%0b, want 1 508 50c 00 (floor)",
                     bus.isControl, bus.oldPC, bus.validAddress, bus.newState);
        end
        tick();
        n_checks++;
        if ({bus.isControl, bus.oldPC} !== {1'b0, 32'h508}) begin
            n_fail++;
            $display("FAIL order_hold: got isc=%0b old=%h, want 0 508 (data held)", bus.isControl, bus.oldPC);
        end
    endtask

    task automatic test_full();
        hold_reset();
        release_reset();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (bus.allocTag !== 3'(i)) begin
                n_fail++;
                $display("FAIL full_tag%0d: got tag=%0d want %0d", i, bus.allocTag, i);
            end
            set_alloc(32'h600 + 32'(4 * i), 32'h0, 1'b0, 8'(i), 2'b01, 1'b0);
            tick();
        end
        n_checks++;
        if ({bus.freeze, bus.allocTag} !== {1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL full_freeze: got frz=%0b tag=%0d, want 1 0", bus.freeze, bus.allocTag);
        end
        set_alloc(32'hDEAD0, 32'h0, 1'b0, 8'hFF, 2'b11, 1'b0);
        tick();
        idle();
        n_checks++;
        if ({bus.freeze, bus.allocTag} !== {1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL full_ignore: got frz=%0b tag=%0d after 9th alloc, want 1 0", bus.freeze, bus.allocTag);
        end
        set_resolve(0, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        n_checks++;
        if ({bus.isControl, bus.oldPC, bus.freeze, bus.allocTag} !== {1'b1, 32'h600, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL full_retire: got isc=%0b old=%h frz=%0b tag=%0d, want 1 600 0 0",
                     bus.isControl, bus.oldPC, bus.freeze, bus.allocTag);
        end
        set_alloc(32'h700, 32'h0, 1'b0, 8'h0, 2'b00, 1'b0);
        tick();
        idle();
        n_checks++;
        if ({bus.freeze, bus.allocTag} !== {1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL full_refill: got frz=%0b tag=%0d, want 1 1", bus.freeze, bus.allocTag);
        end
    endtask

    task automatic test_jal_flush();
        hold_reset();
        release_reset();
        set_alloc(32'h800, 32'h0, 1'b0, 8'h22, 2'b10, 1'b1);
        tick();
        idle();
        set_resolve(0, 1'b0, 32'h900);
        tick();
        idle();
        set_alloc(32'h804, 32'h0, 1'b0, 8'h23, 2'b10, 1'b0);
        tick();
        idle();
        n_checks++;
        if ({bus.mispredict, bus.misdirect, bus.takenBranch, bus.branch, bus.isJAL, bus.writeBTB, bus.validAddress}
            !== {6'b101011, 32'h900}) begin
            n_fail++;
            $display("FAIL jal_retire: got mp=%0b md=%0b tb=%0b br=%0b jal=%0b wb=%0b va=%h, want 1 0 1 0 1 1 900",
                     bus.mispredict, bus.misdirect, bus.takenBranch, bus.branch, bus.isJAL, bus.writeBTB, bus.validAddress);
        end
        n_checks++;
        if ({bus.allocTag, bus.freeze} !== 4'b0) begin
            n_fail++;
            $display("FAIL jal_drop_alloc: got tag=%0d frz=%0b, want 0 0 (same-cycle alloc dropped)",
                     bus.allocTag, bus.freeze);
        end
        set_resolve(0, 1'b1, 32'h0);
        tick();
        idle();
        tick();
        n_checks++;
        if (bus.isControl !== 1'b0) begin
            n_fail++;
            $display("FAIL jal_no_ghost: got isControl=%0b from dropped alloc, want 0", bus.isControl);
        end
    endtask

    task automatic test_random();
        int k;
        hold_reset();
        release_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(99) < 55) begin
                set_alloc($urandom & 32'hFFFF_FFFC, 32'h4000 + 32'($urandom_range(15) * 4),
                          1'($urandom), 8'($urandom), 2'($urandom), ($urandom_range(3) == 0));
            end
            if ($urandom_range(99) < 50) begin
                if (mq.size() > 0 && $urandom_range(9) < 8) begin
                    k = $urandom_range(mq.size() - 1);
                    set_resolve(mq[k].tag,
                                ($urandom_range(9) < 8) ? mq[k].redirect : !mq[k].redirect,
                                ($urandom_range(9) < 8) ? mq[k].pred : 32'h4000 + 32'($urandom_range(15) * 4));
                end else begin
                    set_resolve($urandom_range(DEPTH - 1), 1'($urandom), $urandom);
                end
            end
            n_checks++;
            if ({bus.allocTag, bus.freeze} !== {3'(mtail), (mq.size() == DEPTH)}) begin
                n_fail++;
                $display("FAIL rnd_tag_freeze c=%0d: got tag=%0d frz=%0b want tag=%0d frz=%0b",
                         c, bus.allocTag, bus.freeze, mtail, (mq.size() == DEPTH));
            end
            tick();
            n_checks++;
            if ({bus.mispredict, bus.misdirect, bus.writeBTB, bus.isControl, bus.branch}
                !== {e_mis, e_misd, e_wbtb, e_isc, e_br}) begin
                n_fail++;
                $display("FAIL rnd_pulses c=%0d: got mp/md/wb/isc/br=%b want %b", c,
                         {bus.mispredict, bus.misdirect, bus.writeBTB, bus.isControl, bus.branch},
                         {e_mis, e_misd, e_wbtb, e_isc, e_br});
            end
            n_checks++;
            if ({bus.takenBranch, bus.isJAL, bus.validAddress, bus.target, bus.oldPC, bus.updateIndex, bus.newState}
                !== {e_taken, e_jal, e_va, e_tgt, e_old, e_idx, e_ns}) begin
                n_fail++;
                $display("FAIL rnd_data c=%0d: got tb=%0b jal=%0b va=%h tgt=%h old=%h idx=%h ns=%0b want %0b %0b %h %h %h %h %0b",
                         c, bus.takenBranch, bus.isJAL, bus.validAddress, bus.target, bus.oldPC, bus.updateIndex,
                         bus.newState, e_taken, e_jal, e_va, e_tgt, e_old, e_idx, e_ns);
            end
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        bus.allocValid = 1'b0; bus.allocPC = '0; bus.allocPredictedPC = '0; bus.allocRedirect = 1'b0;
        bus.allocGHRIndex = '0; bus.allocPHTState = '0; bus.allocIsJAL = 1'b0;
        bus.resolveValid = 1'b0; bus.resolveTag = '0; bus.resolveTaken = 1'b0; bus.resolveTarget = '0;
        model_clear();
        test_reset();
        test_mispredict();
        test_misdirect();
        test_in_order();
        test_full();
        test_jal_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
